// File: rtl/ps2_rx_sequencer_if.sv
// ps2_rx_sequencer_if: PS/2 pin inputs plus byte-stream handshake between receiver and consumer.
//  ps2_clk, ps2_data  raw PS/2 pins (asynchronous)
//  rx_ready           consumer accepts rx_data this cycle
//  rx_data, rx_valid  FIFO head byte and not-empty flag
//  frame_err          1-cycle pulse on parity, stop or timeout error
//  overflow           1-cycle pulse when a good byte is dropped on a full FIFO
//  busy               frame in progress
interface ps2_rx_sequencer_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overflow;
    logic       busy;
    modport master (input ps2_clk, ps2_data, rx_ready, output rx_data, rx_valid, frame_err, overflow, busy);
    modport slave (output ps2_clk, ps2_data, rx_ready, input rx_data, rx_valid, frame_err, overflow, busy);
endinterface

// File: rtl/ps2_rx_sequencer.sv
// ps2_rx_sequencer: PS/2 host receiver with frame checking, stall timeout and byte FIFO.
//  clk    system clock, all logic on posedge
//  reset  asynchronous active-high reset
//  bus    ps2_rx_sequencer_if.master: PS/2 pins in, rx_data/rx_valid/rx_ready stream out,
//         frame_err/overflow pulses and busy status
module ps2_rx_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int FIFO_DEPTH     = 4
) (
    input logic               clk,
    input logic               reset,
    ps2_rx_sequencer_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_prev;
    logic [2:0]             bitcnt;
    logic [7:0]             shreg;
    logic                   par;
    logic [TW-1:0]          tcnt;
    logic                   err_q, ovf_q;
    logic [7:0]             mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            count;
    logic                   strobe, bit_in, stop_strobe, good, timeout, full, pop, push, rx_valid;

    assign strobe      = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign bit_in      = data_sync[SYNC_STAGES-1];
    assign stop_strobe = strobe && state == STOP;
    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    assign good        = bit_in & (^shreg ^ par);
    // A strobe arriving in the same cycle wins over the timeout.
    assign timeout     = state != IDLE && !strobe && tcnt == TW'(TIMEOUT_CYCLES);
    assign rx_valid    = count != 0;
    assign full        = count == (AW+1)'(FIFO_DEPTH);
    assign pop         = rx_valid && bus.rx_ready;
    assign push        = stop_strobe && good && (!full || pop);

    assign bus.rx_valid  = rx_valid;
    assign bus.rx_data   = rx_valid ? mem[rd_ptr] : 8'h00;
    assign bus.frame_err = err_q;
    assign bus.overflow  = ovf_q;
    assign bus.busy      = state != IDLE;

    // Synchronizers and edge history reset high so reset release never looks like a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], bus.ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], bus.ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            bitcnt <= '0;
            shreg  <= '0;
            par    <= 1'b0;
            tcnt   <= '0;
            err_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            err_q <= (stop_strobe && !good) || timeout;
            ovf_q <= stop_strobe && good && full && !pop;
            tcnt  <= (strobe || state == IDLE) ? '0 : tcnt + 1'b1;
            if (timeout)
                state <= IDLE;
            else if (strobe)
                case (state)
                    IDLE: if (!bit_in) begin
                        state  <= DATA;
                        bitcnt <= '0;
                    end
                    DATA: begin
                        shreg[bitcnt] <= bit_in;
                        bitcnt        <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= bit_in;
                        state <= STOP;
                    end
                    STOP: state <= IDLE;
                endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shreg;
    end
endmodule
